// File: rtl/fpu_mul_scheduler_pkg.sv
// Shared FPU definitions: word width, field helpers and scheduler state encodings.
package fpu_mul_scheduler_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic fp_sign(input logic [FP_W-1:0] x);
    return x[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fpu_mul_scheduler_multiplier.sv
// Combinational IEEE-754 single multiply: round-to-nearest-even, subnormals flushed to zero.
module multiplier
  import fpu_mul_scheduler_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] p
);

  logic                     sign;
  logic [EXP_W-1:0]         ea, eb;
  logic [MAN_W:0]           ma, mb;
  logic [2*MAN_W+1:0]       prod;
  logic [MAN_W-1:0]         man;
  logic [MAN_W:0]           man_r;
  logic                     guard, sticky;
  logic signed [EXP_W+1:0]  exp_s;
  logic                     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  always_comb begin
    sign   = fp_sign(a) ^ fp_sign(b);
    ea     = fp_exp(a);
    eb     = fp_exp(b);
    ma     = {1'b1, fp_man(a)};
    mb     = {1'b1, fp_man(b)};
    a_nan  = (ea == '1) && (fp_man(a) != '0);
    b_nan  = (eb == '1) && (fp_man(b) != '0);
    a_inf  = (ea == '1) && (fp_man(a) == '0);
    b_inf  = (eb == '1) && (fp_man(b) == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    prod   = {{(MAN_W+1){1'b0}}, ma} * {{(MAN_W+1){1'b0}}, mb};
    exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - (EXP_W+2)'(EXP_BIAS);
    // Product of two [1,2) mantissas lies in [1,4); renormalise when it reaches 2.
    if (prod[2*MAN_W+1]) begin
      man    = prod[2*MAN_W:MAN_W+1];
      guard  = prod[MAN_W];
      sticky = |prod[MAN_W-1:0];
      exp_s  = exp_s + 10'sd1;
    end else begin
      man    = prod[2*MAN_W-1:MAN_W];
      guard  = prod[MAN_W-1];
      sticky = |prod[MAN_W-2:0];
    end
    man_r = {1'b0, man} + {{MAN_W{1'b0}}, guard & (sticky | man[0])};
    if (man_r[MAN_W]) exp_s = exp_s + 10'sd1;
    p = {sign, exp_s[EXP_W-1:0], man_r[MAN_W-1:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) p = FP_QNAN;
    else if (a_inf || b_inf)        p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_zero || b_zero)      p = {sign, {(FP_W-1){1'b0}}};
    else if (exp_s >= 10'sd255)     p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (exp_s <= 10'sd0)       p = {sign, {(FP_W-1){1'b0}}};
  end

endmodule

// File: rtl/fpu_mul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_id    = cand;
      end
    end
  end

endmodule

// File: rtl/fpu_mul_scheduler.sv
// Shares one FP multiplier among NREQ requesters with round-robin grants, one op in flight.
//   state   | meaning
//   ST_IDLE | granting: winner's operands and id are latched on handshake
//   ST_CALC | multiplier evaluates op_a/op_b, product captured into result
//   ST_DONE | response presented until consumed or flushed
module fpu_mul_scheduler
  import fpu_mul_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [FP_W-1:0]      rsp_result,
  output logic                 busy
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [FP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [FP_W-1:0] result_q, result_d;
  logic [FP_W-1:0] mul_p;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  multiplier u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  // Grants are masked during reset as well, so every output reads zero while rst_n is low.
  assign req_ready  = (rst_n && state_q == ST_IDLE && !flush) ? gnt : '0;
  assign rsp_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_ready) begin
          op_a_d   = req_a[int'(gnt_id)*FP_W +: FP_W];
          op_b_d   = req_b[int'(gnt_id)*FP_W +: FP_W];
          id_d     = gnt_id;
          rr_ptr_d = gnt_id;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          result_d = mul_p;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= IDW'(NREQ-1);
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// Self-checking bench for fpu_mul_scheduler: transaction-level model plus directed scenarios.
module tb_fpu_mul_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]    req_ready;
  logic               flush = 1'b0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic               busy;

  logic [31:0] a_arr [NREQ];
  logic [31:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[32*g +: 32] = a_arr[g];
    assign req_b[32*g +: 32] = b_arr[g];
  end

  fpu_mul_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_log [$];
  int gnt_cyc [$];
  logic [31:0] rsp_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed IEEE-754 products for every operand pair the scenarios use.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40400000_40000000: return 32'h40C00000;  //  3.0 *  2.0 =   6.0
      64'hC0000000_3F000000: return 32'hBF800000;  // -2.0 *  0.5 =  -1.0
      64'h3FC00000_3FC00000: return 32'h40100000;  //  1.5 *  1.5 =  2.25
      64'h3F800000_C1200000: return 32'hC1200000;  //  1.0 * -10  = -10.0
      64'h40800000_40A00000: return 32'h41A00000;  //  4.0 *  5.0 =  20.0
      64'h00000000_40400000: return 32'h00000000;  //  0.0 *  3.0 =   0.0
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Model: at most one op outstanding; its response is due two cycles after the handshake.
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_ptr  = NREQ-1;
  int          m_id   = 0;
  logic [31:0] m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_ptr  <= NREQ-1;
      m_id   <= 0;
      m_res  <= '0;
    end else if (m_busy) begin
      if (flush || (m_age >= 2 && rsp_ready)) m_busy <= 1'b0;
      else if (m_age < 2) m_age <= m_age + 1;
    end else if (!flush && pick(req_valid, m_ptr) >= 0) begin
      m_busy <= 1'b1;
      m_age  <= 1;
      m_id   <= pick(req_valid, m_ptr);
      m_ptr  <= pick(req_valid, m_ptr);
      m_res  <= ref_mul(a_arr[pick(req_valid, m_ptr)], b_arr[pick(req_valid, m_ptr)]);
    end
  end

  always @(negedge clk) begin : cmp
    logic [NREQ-1:0] exp_ready;
    int gid;
    exp_ready = '0;
    gid = -1;
    if (rst_n && !m_busy && !flush && pick(req_valid, m_ptr) >= 0)
      exp_ready[pick(req_valid, m_ptr)] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(m_busy));
    check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
    if (m_busy && m_age >= 2) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_result", rsp_result, m_res);
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
    if (gid >= 0) begin
      gnt_log.push_back(gid);
      gnt_cyc.push_back(cyc);
    end
    if (rsp_valid && rsp_ready && !flush) rsp_log.push_back(rsp_result);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the handshake edge, i.e. in the first CALC cycle.
  task automatic wait_grant(output int id, output int gc);
    id = -1;
    gc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
      if (id >= 0) begin
        gc = cyc;
        step();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout actual=none required=grant at t=%0t", $time);
  endtask

  // Returns at the falling edge of the first cycle with rsp_valid high.
  task automatic wait_rsp(output int rc, output logic [31:0] res, output int rid);
    rc = -1;
    res = '0;
    rid = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rc = cyc;
        res = rsp_result;
        rid = int'(rsp_id);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL rsp_timeout actual=none required=rsp_valid at t=%0t", $time);
  endtask

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_p);
    int id, gc, rc, rid;
    logic [31:0] res;
    a_arr[idx] = a;
    b_arr[idx] = b;
    req_valid = NREQ'(1 << idx);
    wait_grant(id, gc);
    req_valid = '0;
    check("op_grant_id", 32'(id), 32'(idx));
    wait_rsp(rc, res, rid);
    check("op_latency", 32'(rc - gc), 32'd2);
    check("op_result", res, exp_p);
    check("op_rsp_id", 32'(rid), 32'(idx));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int id, gc, rc, rid, n, g, g2, g3;
    logic [31:0] res;
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    repeat (3) step();
    check("reset_rsp_result", rsp_result, 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();

    // Single op and operand sign/normalisation cases; requester 2 alone is granted twice.
    do_op(0, 32'h40400000, 32'h40000000, 32'h40C00000);
    do_op(1, 32'hC0000000, 32'h3F000000, 32'hBF800000);
    do_op(2, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    do_op(2, 32'h3F800000, 32'hC1200000, 32'hC1200000);
    do_op(3, 32'h00000000, 32'h40400000, 32'h00000000);

    // Fairness from a fresh pointer with all requesters pending.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a_arr[0] = 32'h40400000; b_arr[0] = 32'h40000000;
    a_arr[1] = 32'hC0000000; b_arr[1] = 32'h3F000000;
    a_arr[2] = 32'h3FC00000; b_arr[2] = 32'h3FC00000;
    a_arr[3] = 32'h40800000; b_arr[3] = 32'h40A00000;
    gnt_log.delete();
    gnt_cyc.delete();
    req_valid = '1;
    repeat (19) step();
    req_valid = '0;
    check("fair_count_ok", 32'(gnt_log.size() >= 6), 32'd1);
    if (gnt_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) check("fair_order", 32'(gnt_log[i]), 32'(exp_order[i]));
      for (int i = 1; i < 6; i++) check("fair_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
    end
    repeat (4) step();

    // Backpressure: response held for five cycles, then released.
    rsp_ready = 1'b0;
    req_valid = '1;
    wait_grant(id, gc);
    wait_rsp(rc, res, rid);
    check("bp_result", res, ref_mul(a_arr[id], b_arr[id]));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result_stable", rsp_result, res);
      check("bp_id_stable", 32'(rsp_id), 32'(rid));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("bp_last_done", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("bp_idle_after", 32'(busy), 32'd0);
    step();

    // Flush in CALC drops the op; the pointer still advances past the flushed winner.
    req_valid = '1;
    wait_grant(g, gc);
    req_valid = '0;
    n = rsp_log.size();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    check("flush_calc_no_rsp", 32'(rsp_log.size()), 32'(n));
    req_valid = '1;
    wait_grant(g2, gc);
    check("flush_calc_next", 32'(g2), 32'((g + 1) % NREQ));

    // Flush coinciding with rsp_ready in DONE: flush wins, no response.
    req_valid = '0;
    rsp_ready = 1'b0;
    wait_rsp(rc, res, rid);
    n = rsp_log.size();
    @(posedge clk);
    #1;
    flush = 1'b1;
    rsp_ready = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();
    check("flush_done_no_rsp", 32'(rsp_log.size()), 32'(n));
    check("flush_done_idle", 32'(busy), 32'd0);
    req_valid = '1;
    wait_grant(g3, gc);
    check("flush_done_next", 32'(g3), 32'((g2 + 1) % NREQ));
    req_valid = '0;
    repeat (4) step();

    // Asynchronous reset while in CALC.
    req_valid = '1;
    wait_grant(id, gc);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_rsp_id", 32'(rsp_id), 32'd0);
    check("arst_rsp_result", rsp_result, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_grant(id, gc);
    check("arst_first_grant", 32'(id), 32'd0);
    req_valid = '0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
